// File: rtl/st_c2h_cmpt_engine.sv
// st_c2h_cmpt_engine: queues one completion per C2H packet end and streams 8/16/32/64B CMPT beats.
// Optional CMPT_PARITY_EN adds registered odd parity per 32-bit lane of cmpt_tdata.
module st_c2h_cmpt_engine #(
  parameter int CMPT_DW    = 128,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic                          c2h_tvalid,
  input  logic                          c2h_tready,
  input  logic                          c2h_tlast,
  input  logic [10:0]                   c2h_qid,
  input  logic [2:0]                    cmpt_cfg,
  input  logic                          cmpt_dis,
  input  logic [511:0]                  wb_dat,
  output logic [CMPT_DW-1:0]            cmpt_tdata,
  output logic [1:0]                    cmpt_size,
  output logic [CMPT_DW/32-1:0]         cmpt_dpar,
  output logic                          cmpt_tvalid,
  output logic                          cmpt_tlast,
  input  logic                          cmpt_tready,
  output logic [$clog2(FIFO_DEPTH):0]   pend_count,
  output logic [CNT_W-1:0]              drop_count,
  output logic                          c2h_hold
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NB = 512 / CMPT_DW;
  localparam int BW = $clog2(NB);
  localparam int EW = 11 + 3 + 512;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic logic [BW-1:0] last_of(input logic [1:0] s);
    int n;
    n = (64 << s) / CMPT_DW;
    return BW'(n > 0 ? n - 1 : 0);
  endfunction
  logic [EW-1:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               hold_q, hold_d;
  state_t             state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d, nxt;
  logic [1:0]         size_q, size_d;
  logic               tlast_q, tlast_d;
  logic [CMPT_DW-1:0] tdata_q, tdata_d;
  logic [511:0]       wb_q, wb_d;
  logic [10:0]        h_qid;
  logic [2:0]         h_cfg;
  logic [511:0]       h_wb;
  logic [CMPT_DW-1:0] wb_beats [NB];
  logic               push, full, push_ok, hs, load, adv;
  assign {h_qid, h_cfg, h_wb} = mem[rd_q];
  for (genvar i = 0; i < NB; i++) begin : g_beats
    assign wb_beats[i] = wb_q[i*CMPT_DW +: CMPT_DW];
  end
  always_comb begin
    push    = c2h_tvalid & c2h_tready & c2h_tlast & ~cmpt_dis;
    full    = cnt_q == CW'(FIFO_DEPTH);
    push_ok = push & ~full;
    hs      = (state_q == SEND) & cmpt_tready;
    // Refill the output regs when idle or as the last beat retires, so back-to-back entries have no bubble.
    load    = (cnt_q != '0) & ((state_q == IDLE) | (hs & tlast_q));
    adv     = hs & ~tlast_q;
    nxt     = beat_q + BW'(1);
    wr_d    = push_ok ? wr_q + PW'(1) : wr_q;
    rd_d    = load ? rd_q + PW'(1) : rd_q;
    cnt_d   = cnt_q + CW'(push_ok) - CW'(load);
    drop_d  = (push & full & ~&drop_q) ? drop_q + CNT_W'(1) : drop_q;
    hold_d  = cnt_d == CW'(FIFO_DEPTH);
    state_d = load ? SEND : (hs & tlast_q) ? IDLE : state_q;
    beat_d  = load ? '0 : adv ? nxt : beat_q;
    size_d  = load ? h_cfg[1:0] : size_q;
    wb_d    = load ? h_wb : wb_q;
    tlast_d = load ? (last_of(h_cfg[1:0]) == '0) : adv ? (nxt == last_of(size_q)) : tlast_q;
    tdata_d = load ? {h_wb[CMPT_DW-1:20], 8'h0, h_qid, h_cfg[2]} : adv ? wb_beats[nxt] : tdata_q;
  end
  always_ff @(posedge axi_aclk)
    if (push_ok) mem[wr_q] <= {c2h_qid, cmpt_cfg, wb_dat};
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      hold_q  <= 1'b0;
      state_q <= IDLE;
      beat_q  <= '0;
      size_q  <= '0;
      tlast_q <= 1'b0;
      tdata_q <= '0;
      wb_q    <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
      state_q <= state_d;
      beat_q  <= beat_d;
      size_q  <= size_d;
      tlast_q <= tlast_d;
      tdata_q <= tdata_d;
      wb_q    <= wb_d;
    end
  end
`ifdef CMPT_PARITY_EN
  logic [CMPT_DW/32-1:0] dpar_q, dpar_d;
  always_comb begin
    dpar_d = '0;
    for (int j = 0; j < CMPT_DW/32; j++) dpar_d[j] = ~^tdata_d[j*32 +: 32];
  end
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) dpar_q <= '0;
    else dpar_q <= dpar_d;
  assign cmpt_dpar = dpar_q;
`else
  assign cmpt_dpar = '0;
`endif
  assign cmpt_tdata  = tdata_q;
  assign cmpt_size   = size_q;
  assign cmpt_tvalid = state_q == SEND;
  assign cmpt_tlast  = tlast_q;
  assign pend_count  = cnt_q;
  assign drop_count  = drop_q;
  assign c2h_hold    = hold_q;
endmodule

// File: tb/tb_st_c2h_cmpt_engine.sv
// tb_st_c2h_cmpt_engine: directed vectors plus multi-cycle sequences for the CMPT engine
// (CMPT_DW=128, FIFO_DEPTH=4).
module tb_st_c2h_cmpt_engine;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         c2h_tvalid, c2h_tready, c2h_tlast, cmpt_dis;
  logic [10:0]  c2h_qid;
  logic [2:0]   cmpt_cfg;
  logic [511:0] wb_dat;
  logic [127:0] cmpt_tdata;
  logic [1:0]   cmpt_size;
  logic [3:0]   cmpt_dpar;
  logic         cmpt_tvalid, cmpt_tlast, cmpt_tready;
  logic [2:0]   pend_count;
  logic [15:0]  drop_count;
  logic         c2h_hold;
  int checks = 0;
  int errors = 0;

  st_c2h_cmpt_engine #(.CMPT_DW(128), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .c2h_tvalid(c2h_tvalid), .c2h_tready(c2h_tready), .c2h_tlast(c2h_tlast),
    .c2h_qid(c2h_qid), .cmpt_cfg(cmpt_cfg), .cmpt_dis(cmpt_dis), .wb_dat(wb_dat),
    .cmpt_tdata(cmpt_tdata), .cmpt_size(cmpt_size), .cmpt_dpar(cmpt_dpar),
    .cmpt_tvalid(cmpt_tvalid), .cmpt_tlast(cmpt_tlast), .cmpt_tready(cmpt_tready),
    .pend_count(pend_count), .drop_count(drop_count), .c2h_hold(c2h_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] qid;
    logic [2:0]  cfg;
    bit          stall;
    logic [19:0] lo;
    int          nb;
  } vec_t;
  vec_t vec [5];

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [511:0] wfor(input logic [10:0] q);
    logic [511:0] base;
    base = {128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 128'h0123456789ABCDEFFEDCBA9876543210,
            128'hDEADBEEFCAFEF00D0BADC0DE12345678, 128'hA5A5A5A55A5A5A5A3C3C3C3CC3C3C3C3};
    return base ^ {16{21'h0, q}};
  endfunction

  function automatic logic [127:0] exp_beat(input logic [10:0] q, input logic [2:0] c, input int k);
    logic [511:0] w;
    w = wfor(q);
    return k == 0 ? {w[127:20], 8'h0, q, c[2]} : w[k*128 +: 128];
  endfunction

  function automatic logic [3:0] exp_par(input logic [127:0] d);
    logic [3:0] p;
    p = '0;
`ifdef CMPT_PARITY_EN
    for (int j = 0; j < 4; j++) p[j] = ~^d[j*32 +: 32];
`endif
    return p;
  endfunction

  task automatic burst(input logic [10:0] q0, input logic [2:0] c, input int n, input bit dis);
    for (int i = 0; i < n; i++) begin
      c2h_tvalid = 1'b1;
      c2h_tready = 1'b1;
      c2h_tlast  = 1'b1;
      c2h_qid    = q0 + 11'(i);
      cmpt_cfg   = c;
      cmpt_dis   = dis;
      wb_dat     = wfor(q0 + 11'(i));
      @(negedge clk);
    end
    c2h_tvalid = 1'b0;
    c2h_tlast  = 1'b0;
    cmpt_dis   = 1'b0;
  endtask

  task automatic expect_cmpt(input logic [10:0] q, input logic [2:0] c, input int nb, input bit stall);
    logic [127:0] e;
    for (int k = 0; k < nb; k++) begin
      int t = 0;
      while (cmpt_tvalid !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (cmpt_tvalid !== 1'b1) begin
        check("tvalid_timeout", cmpt_tvalid, 1);
        return;
      end
      e = exp_beat(q, c, k);
      check("tdata", cmpt_tdata, e);
      check("tlast", cmpt_tlast, k == nb - 1);
      check("size", cmpt_size, c[1:0]);
      check("dpar", cmpt_dpar, exp_par(e));
      if (stall) begin
        cmpt_tready = 1'b0;
        @(negedge clk);
        check("stall_tvalid", cmpt_tvalid, 1);
        check("stall_tdata", cmpt_tdata, e);
        check("stall_tlast", cmpt_tlast, k == nb - 1);
        cmpt_tready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    vec[0] = '{11'h005, 3'b000, 1'b0, 20'h0000A, 1};
    vec[1] = '{11'h7FF, 3'b100, 1'b0, 20'h00FFF, 1};
    vec[2] = '{11'h123, 3'b001, 1'b1, 20'h00246, 1};
    vec[3] = '{11'h2AA, 3'b110, 1'b1, 20'h00555, 2};
    vec[4] = '{11'h055, 3'b011, 1'b1, 20'h000AA, 4};
    c2h_tvalid = 1'b0; c2h_tready = 1'b0; c2h_tlast = 1'b0; cmpt_dis = 1'b0;
    c2h_qid = '0; cmpt_cfg = '0; wb_dat = '0; cmpt_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tvalid", cmpt_tvalid, 0);
    check("rst_tlast", cmpt_tlast, 0);
    check("rst_tdata", cmpt_tdata, '0);
    check("rst_size", cmpt_size, 0);
    check("rst_dpar", cmpt_dpar, 0);
    check("rst_pend", pend_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_hold", c2h_hold, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int v = 0; v < 5; v++) begin
      burst(vec[v].qid, vec[v].cfg, 1, 1'b0);
      check("push_tvalid_low", cmpt_tvalid, 0);
      check("push_pend", pend_count, 1);
      @(negedge clk);
      check("latency_tvalid", cmpt_tvalid, 1);
      check("hdr_lo20", cmpt_tdata[19:0], vec[v].lo);
      check("pop_pend", pend_count, 0);
      expect_cmpt(vec[v].qid, vec[v].cfg, vec[v].nb, vec[v].stall);
      check("vec_idle", cmpt_tvalid, 0);
    end
    burst(11'h077, 3'b000, 1, 1'b1);
    repeat (3) @(negedge clk);
    check("dis_tvalid", cmpt_tvalid, 0);
    check("dis_pend", pend_count, 0);
    check("dis_drop", drop_count, 0);
    cmpt_tready = 1'b0;
    burst(11'h010, 3'b001, 2, 1'b0);
    check("b2b_pend", pend_count, 1);
    cmpt_tready = 1'b1;
    check("b2b_v0", cmpt_tvalid, 1);
    check("b2b_q0", cmpt_tdata[11:1], 11'h010);
    check("b2b_l0", cmpt_tlast, 1);
    @(negedge clk);
    check("b2b_v1", cmpt_tvalid, 1);
    check("b2b_q1", cmpt_tdata[11:1], 11'h011);
    check("b2b_l1", cmpt_tlast, 1);
    @(negedge clk);
    check("b2b_idle", cmpt_tvalid, 0);
    cmpt_tready = 1'b0;
    burst(11'h020, 3'b000, 6, 1'b0);
    check("full_pend", pend_count, 4);
    check("full_hold", c2h_hold, 1);
    check("full_drop", drop_count, 1);
    check("full_tvalid", cmpt_tvalid, 1);
    check("full_head", cmpt_tdata[11:1], 11'h020);
    cmpt_tready = 1'b1;
    for (int i = 0; i < 5; i++) expect_cmpt(11'h020 + 11'(i), 3'b000, 1, 1'b0);
    check("drain_idle", cmpt_tvalid, 0);
    check("drain_pend", pend_count, 0);
    check("drain_hold", c2h_hold, 0);
    burst(11'h03C, 3'b011, 1, 1'b0);
    burst(11'h03D, 3'b000, 1, 1'b0);
    check("r_beat0", cmpt_tdata, exp_beat(11'h03C, 3'b011, 0));
    check("r_pend", pend_count, 1);
    @(negedge clk);
    check("r_beat1", cmpt_tdata, exp_beat(11'h03C, 3'b011, 1));
    #1 rst_n = 1'b0;
    #1;
    check("r_tvalid", cmpt_tvalid, 0);
    check("r_pend0", pend_count, 0);
    check("r_drop0", drop_count, 0);
    check("r_hold0", c2h_hold, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmpt_tvalid) seen++;
    end
    check("post_reset_beats", seen, 0);
    burst(11'h041, 3'b010, 1, 1'b0);
    expect_cmpt(11'h041, 3'b010, 2, 1'b0);
    check("final_idle", cmpt_tvalid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
